uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/config_pkg.sv | 23 ++
 rtl/uart_fifo.sv | 77 +++++++
 rtl/uart_tx.sv | 114 +++++++++++
 tb/tb_uart_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared configuration for the UART transmit path.
// Holds CSR addresses, FIFO sizing, bit timing and the tx FSM state type.
package config_pkg;

    localparam int UartCmpVal    = 173;
    localparam int FifoQueueSize = 256;
    localparam int FifoDataWidth = 8;

    typedef logic [11:0] CsrAddrT;
    typedef logic [31:0] RegT;
    typedef logic [$clog2(FifoQueueSize)-1:0] FifoPtrT;

    localparam CsrAddrT FifoWordCsrAddr = 12'h050;
    localparam CsrAddrT FifoByteCsrAddr = 12'h051;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO feeding the UART serializer: 1- or 4-byte push, 1-byte pop.
// Ports: clk, reset, push_byte, push_word, data, pop -> head, count, full, overflow.
module uart_fifo
    import config_pkg::*;
#(
    parameter int Depth = FifoQueueSize
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_byte,
    input  logic                   push_word,
    input  logic [31:0]            data,
    input  logic                   pop,
    output logic [7:0]             head,
    output logic [$clog2(Depth):0] count,
    output logic                   full,
    output logic                   overflow
);

    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] DepthC = (AW+1)'(Depth);
    localparam logic [AW:0] OneC   = (AW+1)'(1);
    localparam logic [AW:0] FourC  = (AW+1)'(4);

    logic [FifoDataWidth-1:0] mem [Depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   free;
    logic          byte_ok;
    logic          word_ok;
    logic          drop;
    logic          do_pop;
    logic [AW:0]   n_push;

    // Free space is taken from the registered count only, so a pop
    // in the same cycle never makes room for the push.
    always_comb begin
        free    = DepthC - count;
        byte_ok = push_byte && (free >= OneC);
        word_ok = push_word && (free >= FourC);
        drop    = (push_byte && !byte_ok) || (push_word && !word_ok);
        do_pop  = pop && (count != '0);
        n_push  = '0;
        if (word_ok)
            n_push = FourC;
        else if (byte_ok)
            n_push = OneC;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + n_push[AW-1:0];
            rd_ptr   <= rd_ptr + AW'(do_pop);
            count    <= count + n_push - (AW+1)'(do_pop);
            overflow <= overflow | drop;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (word_ok) begin
            for (int i = 0; i < 4; i++)
                mem[wr_ptr + AW'(i)] <= data[8*i +: 8];
        end else if (byte_ok) begin
            mem[wr_ptr] <= data[7:0];
        end
    end

    assign head = mem[rd_ptr];
    assign full = (count == DepthC);

endmodule

// File: rtl/uart_tx.sv
// CSR-fed UART transmitter: FIFO plus 8N1 serializer FSM.
// Ports: clk, reset, csr_enable/addr/data -> tx, fifo_count, fifo_full, overflow, busy.
module uart_tx
    import config_pkg::*;
#(
    parameter int CmpVal = UartCmpVal,
    parameter int Depth  = FifoQueueSize
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   csr_enable,
    input  logic [11:0]            csr_addr,
    input  logic [31:0]            csr_data,
    output logic                   tx,
    output logic [$clog2(Depth):0] fifo_count,
    output logic                   fifo_full,
    output logic                   overflow,
    output logic                   busy
);

    localparam int TW = (CmpVal > 1) ? $clog2(CmpVal) : 1;
    localparam logic [TW-1:0] TLast = TW'(CmpVal - 1);

    uart_tx_state_t state;
    logic [TW-1:0]  timer;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic [7:0]     head;
    logic           push_byte;
    logic           push_word;
    logic           pop;
    logic           bit_done;

    assign push_byte = csr_enable && (csr_addr == FifoByteCsrAddr);
    assign push_word = csr_enable && (csr_addr == FifoWordCsrAddr);
    assign pop       = (state == IDLE) && (fifo_count != '0);
    assign bit_done  = (timer == TLast);
    assign busy      = (state != IDLE) || (fifo_count != '0);

    uart_fifo #(
        .Depth(Depth)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_byte(push_byte),
        .push_word(push_word),
        .data     (csr_data),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count),
        .full     (fifo_full),
        .overflow (overflow)
    );

    // tx is registered and loaded with the value of the state being
    // entered, so each level lasts exactly CmpVal cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        shreg <= head;
                        timer <= '0;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: line decoder monitor vs expected byte queue.
// Directed frame/FIFO boundary cases followed by randomized CSR traffic.
module tb_uart_tx;

    localparam int C     = 16;
    localparam int D     = 256;
    localparam int FRAME = 10 * C + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csr_enable = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_data = '0;
    logic        tx;
    logic [8:0]  fifo_count;
    logic        fifo_full;
    logic        overflow;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    int starts[$];

    uart_tx #(
        .CmpVal(C),
        .Depth (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .csr_enable(csr_enable),
        .csr_addr  (csr_addr),
        .csr_data  (csr_data),
        .tx        (tx),
        .fifo_count(fifo_count),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; the write is sampled by the next posedge.
    task automatic wr(input logic [11:0] a, input logic [31:0] d,
                      input bit accept);
        csr_enable = 1'b1;
        csr_addr   = a;
        csr_data   = d;
        if (accept) begin
            if (a == 12'h051)
                exp_q.push_back(d[7:0]);
            else if (a == 12'h050)
                for (int i = 0; i < 4; i++)
                    exp_q.push_back(d[8*i +: 8]);
        end
        @(negedge clk);
        csr_enable = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        check("drain_busy", busy, 0);
        check("drain_tx", tx, 1);
        check("drain_count", fifo_count, 0);
    endtask

    // Line monitor: decodes 8N1 frames from tx and checks every cycle of
    // every bit period is flat, then scores the byte.
    initial begin
        logic [9:0] val;
        bit shape_ok;
        bit aborted;
        int i;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                starts.push_back(cyc);
                shape_ok = 1'b1;
                aborted  = 1'b0;
                val      = '0;
                i        = 0;
                while (i < 10 * C && !aborted) begin
                    if (i > 0) @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                    end else begin
                        if (i % C == 0)
                            val[i / C] = tx;
                        else if (tx !== val[i / C])
                            shape_ok = 1'b0;
                        i++;
                    end
                end
                if (!aborted) begin
                    check("frame_shape", {shape_ok, val[0], val[9]}, 3'b101);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got 0x%0h, want none",
                                 val[8:1]);
                    end else begin
                        check("frame_byte", val[8:1], exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s;
        int lows;
        int r;
        logic [31:0] d;
        logic [11:0] a;

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_count", fifo_count, 0);
        check("rst_full", fifo_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rel_tx", tx, 1);

        // Single byte 0x55: exact start latency, stop and busy fall.
        wr(12'h051, 32'h55, 1);
        check("b_count", fifo_count, 1);
        check("b_tx_pre", tx, 1);
        @(negedge clk);
        check("b_start_low", tx, 0);
        check("b_busy", busy, 1);
        repeat (10 * C - 1) @(negedge clk);
        check("b_stop_high", tx, 1);
        check("b_busy_stop", busy, 1);
        @(negedge clk);
        check("b_busy_fall", busy, 0);
        check("b_idle_tx", tx, 1);

        // Word write: four frames in order, one idle cycle apart.
        starts.delete();
        wr(12'h050, 32'h44332211, 1);
        check("w_count", fifo_count, 4);
        wait_drain(5 * FRAME);
        check("w_frames", starts.size(), 4);
        for (int j = 1; j < 4 && j < starts.size(); j++)
            check("w_gap", starts[j] - starts[j-1], FRAME);

        // Push lands on the same edge as the IDLE pop at count 1.
        wr(12'h051, 32'hA5, 1);
        check("pp_count1", fifo_count, 1);
        wr(12'h051, 32'h3C, 1);
        check("pp_same_cycle", fifo_count, 1);
        wait_drain(3 * FRAME);

        // Fill to Depth while the first frame stalls the line.
        wr(12'h051, 32'h00, 1);
        for (int j = 0; j < 64; j++)
            wr(12'h050, $urandom, 1);
        check("f_count", fifo_count, D);
        check("f_full", fifo_full, 1);
        check("f_ovf0", overflow, 0);
        wr(12'h051, 32'h77, 0);
        check("f_drop_count", fifo_count, D);
        check("f_drop_ovf", overflow, 1);
        n = 0;
        while (fifo_count != 9'd253 && n < 5 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("f_reach253", fifo_count, 253);
        wr(12'h050, $urandom, 0);
        check("f_word_drop", fifo_count, 253);
        check("f_word_ovf", overflow, 1);
        wr(12'h051, 32'h9E, 1);
        check("f_byte_ok", fifo_count, 254);
        check("f_ovf_sticky", overflow, 1);

        // Asynchronous reset in the middle of a data bit.
        s = starts.size();
        n = 0;
        while (starts.size() == s && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        repeat (C + 3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("ar_tx", tx, 1);
        check("ar_count", fifo_count, 0);
        check("ar_busy", busy, 0);
        check("ar_ovf", overflow, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        lows = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("ar_no_resume", lows, 0);

        // Randomized CSR traffic, including writes to unrelated addresses.
        for (int j = 0; j < 12; j++) begin
            r = $urandom_range(0, 2);
            d = $urandom;
            if (r == 0) begin
                wr(12'h051, d, 1);
            end else if (r == 1) begin
                wr(12'h050, d, 1);
            end else begin
                a = 12'($urandom_range(0, 4095));
                if (a == 12'h050 || a == 12'h051) a = 12'h052;
                wr(a, d, 0);
            end
            repeat ($urandom_range(0, 300)) @(negedge clk);
        end
        wait_drain(60 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
